// File: rtl/tx_packet_scheduler_pkg.sv
// Shared constants for the transmit packet scheduler: default buffer size,
// inter-frame gap, descriptor queue depth, watchdog limit and FSM state codes.
package tx_packet_scheduler_pkg;

  localparam int PACKET_BUFFER_SIZE = 2048;
  localparam int TX_GAP_CYCLES      = 48;
  localparam int TX_QUEUE_DEPTH     = 4;
  localparam int TX_TIMEOUT_CYCLES  = 4096;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_STREAM = 3'd2;
  localparam logic [2:0] ST_DRAIN  = 3'd3;
  localparam logic [2:0] ST_GAP    = 3'd4;

  // True when value is a positive power of two.
  function automatic bit is_pow2(input int value);
    return (value > 0) && ((value & (value - 1)) == 0);
  endfunction

endpackage

// File: rtl/tx_packet_scheduler_if.sv
// Signal bundle between the packet builder / memory streamer / serializer side
// (master) and the transmit scheduler (slave).
interface tx_packet_scheduler_if
  import tx_packet_scheduler_pkg::*;
#(
  parameter int AW = $clog2(PACKET_BUFFER_SIZE)
);

  logic          desc_inclk;
  logic [AW-1:0] desc_start;
  logic [AW-1:0] desc_end;
  logic          queue_full;
  logic          queue_empty;
  logic          overflow;
  logic          sfm_start;
  logic [AW-1:0] sfm_read_start;
  logic [AW-1:0] sfm_read_end;
  logic          sfm_done;
  logic          tx_done;
  logic          busy;
  logic          pkt_sent;
  logic          pkt_err;

  modport master (
    output desc_inclk, desc_start, desc_end, sfm_done, tx_done,
    input  queue_full, queue_empty, overflow, sfm_start, sfm_read_start,
           sfm_read_end, busy, pkt_sent, pkt_err
  );

  modport slave (
    input  desc_inclk, desc_start, desc_end, sfm_done, tx_done,
    output queue_full, queue_empty, overflow, sfm_start, sfm_read_start,
           sfm_read_end, busy, pkt_sent, pkt_err
  );

endinterface

// File: rtl/tx_packet_scheduler_descriptor_fifo.sv
// Synchronous descriptor FIFO: head entry visible without a read strobe,
// registered full/empty flags, and a push is still taken when full provided
// the head is popped in the same cycle. A dropped push pulses overflow.
module tx_packet_scheduler_descriptor_fifo #(
  parameter int DW    = 22,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] head,
  output logic          full,
  output logic          empty,
  output logic          overflow
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic [PW:0]   count_nxt;
  logic          do_push;
  logic          do_pop;

  assign do_pop    = pop && !empty;
  assign do_push   = push && (!full || do_pop);
  assign count_nxt = count + (PW+1)'(do_push) - (PW+1)'(do_pop);
  assign head      = mem[rd_ptr];

  // Storage write.
  // NOTE: the data array has no reset; entries are only ever read after a
  // push has written them, so clearing it would just cost reset fan-out.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers, occupancy and registered flags.
  // NOTE: every state register uses non-blocking assignment so all flops
  // update together at the edge regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count    <= count_nxt;
      full     <= (count_nxt == (PW+1)'(DEPTH));
      empty    <= (count_nxt == '0);
      overflow <= push && !do_push;
    end
  end

endmodule

// File: rtl/tx_packet_scheduler.sv
// Transmit packet scheduler: queues (start,end) descriptors, launches the
// memory streamer for one packet at a time, waits for the serializer to
// drain, then holds an inter-frame gap before the next packet.
// Optional build macro TX_SCHED_TIMEOUT_EN adds a STREAM+DRAIN watchdog that
// aborts a stuck packet with a pkt_err pulse.
module tx_packet_scheduler
  import tx_packet_scheduler_pkg::*;
#(
  parameter int RAM_SIZE       = PACKET_BUFFER_SIZE,
  parameter int QUEUE_DEPTH    = TX_QUEUE_DEPTH,
  parameter int GAP_CYCLES     = TX_GAP_CYCLES,
  parameter int TIMEOUT_CYCLES = TX_TIMEOUT_CYCLES
) (
  input  logic                 clk,
  input  logic                 rst,
  tx_packet_scheduler_if.slave bus
);

  localparam int         AW       = $clog2(RAM_SIZE);
  localparam int         GW       = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
  localparam int         GAP_LOAD = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam logic [2:0] ST_AFTER = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;

  if (!is_pow2(RAM_SIZE)) begin : g_bad_ram_size
    $error("RAM_SIZE must be a power of two");
  end
  if (!is_pow2(QUEUE_DEPTH) || QUEUE_DEPTH < 2) begin : g_bad_depth
    $error("QUEUE_DEPTH must be a power of two and at least 2");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  logic [2:0]    state;
  logic [2:0]    state_nxt;
  logic [2*AW-1:0] head;
  logic          head_zero;
  logic          pop;
  logic          tx_seen;
  logic          done_seen;
  logic          timeout;
  logic [GW-1:0] gap_cnt;
  logic          pkt_sent_q;

  assign head_zero = (head[2*AW-1:AW] == head[AW-1:0]);
  // The head leaves the queue when launched, or when it is an empty packet
  // being discarded while idle.
  assign pop       = (state == ST_START) ||
                     ((state == ST_IDLE) && !bus.queue_empty && head_zero);
  assign done_seen = bus.tx_done || tx_seen;

  tx_packet_scheduler_descriptor_fifo #(
    .DW    (2*AW),
    .DEPTH (QUEUE_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (bus.desc_inclk),
    .push_data ({bus.desc_start, bus.desc_end}),
    .pop       (pop),
    .head      (head),
    .full      (bus.queue_full),
    .empty     (bus.queue_empty),
    .overflow  (bus.overflow)
  );

`ifdef TX_SCHED_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES) + 1;

  logic [WW-1:0] wd_cnt;
  logic          pkt_err_q;

  assign timeout = ((state == ST_STREAM) || (state == ST_DRAIN)) &&
                   (wd_cnt == WW'(TIMEOUT_CYCLES - 1));
  assign bus.pkt_err = pkt_err_q;

  // Watchdog: cleared while launching, counts every STREAM/DRAIN cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt <= '0;
    end else if (state == ST_START) begin
      wd_cnt <= '0;
    end else if ((state == ST_STREAM) || (state == ST_DRAIN)) begin
      wd_cnt <= wd_cnt + WW'(1);
    end
  end

  // Abort pulse, suppressed when the packet completes in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) pkt_err_q <= 1'b0;
    else     pkt_err_q <= timeout && !((state == ST_DRAIN) && done_seen);
  end
`else
  assign timeout     = 1'b0;
  assign bus.pkt_err = 1'b0;
`endif

  // Next-state decode.
  // NOTE: state_nxt is assigned before the case so every path drives it and
  // no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (!bus.queue_empty && !head_zero) state_nxt = ST_START;
      ST_START:  state_nxt = ST_STREAM;
      ST_STREAM: if (timeout)           state_nxt = ST_AFTER;
                 else if (bus.sfm_done) state_nxt = ST_DRAIN;
      ST_DRAIN:  if (done_seen || timeout) state_nxt = ST_AFTER;
      ST_GAP:    if (gap_cnt == '0)     state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Capture the head addresses as the launch is decided; held until next launch.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.sfm_read_start <= '0;
      bus.sfm_read_end   <= '0;
    end else if ((state == ST_IDLE) && (state_nxt == ST_START)) begin
      bus.sfm_read_start <= head[2*AW-1:AW];
      bus.sfm_read_end   <= head[AW-1:0];
    end
  end

  // Remember a serializer-done that arrives before the streamer finishes.
  always_ff @(posedge clk) begin
    if (rst) tx_seen <= 1'b0;
    else     tx_seen <= ((state == ST_STREAM) && (tx_seen || bus.tx_done)) ||
                        ((state == ST_DRAIN) && tx_seen && (state_nxt == ST_DRAIN));
  end

  // Inter-frame gap counter, loaded on entry to GAP.
  always_ff @(posedge clk) begin
    if (rst) begin
      gap_cnt <= '0;
    end else if ((state_nxt == ST_GAP) && (state != ST_GAP)) begin
      gap_cnt <= GW'(GAP_LOAD);
    end else if ((state == ST_GAP) && (gap_cnt != '0)) begin
      gap_cnt <= gap_cnt - GW'(1);
    end
  end

  // Completion pulse, one cycle after DRAIN sees the serializer done.
  always_ff @(posedge clk) begin
    if (rst) pkt_sent_q <= 1'b0;
    else     pkt_sent_q <= (state == ST_DRAIN) && done_seen;
  end

  assign bus.pkt_sent  = pkt_sent_q;
  assign bus.sfm_start = (state == ST_START);
  assign bus.busy      = (state != ST_IDLE);

endmodule
